// File: rtl/rpn_pkg.sv
// rpn_pkg: shared types and constants for the RPN calculator controller.
// FSM state and command encodings, ALU function codes, and the front-panel
// command decoder used by rpn_ctrl.
package rpn_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP,
        CLR,
        READ,
        WRITE
    } state_e;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_PUSH,
        CMD_POP,
        CMD_CLR,
        CMD_BIN
    } cmd_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // KEY0 outranks KEY1 when both fire in the same cycle; KEY2/KEY3 carry no command.
    function automatic cmd_e decode_cmd(input logic [1:0] mode, input logic [1:0] press);
        cmd_e cmd;
        cmd = CMD_NONE;
        if (press[0]) begin
            unique case (mode)
                2'b00:        cmd = CMD_PUSH;
                2'b01, 2'b10: cmd = CMD_BIN;
                default:      cmd = CMD_NONE;
            endcase
        end else if (press[1]) begin
            unique case (mode)
                2'b00:        cmd = CMD_POP;
                2'b01, 2'b10: cmd = CMD_BIN;
                default:      cmd = CMD_CLR;
            endcase
        end
        return cmd;
    endfunction

    // ALU function for a binary op: mode 01 selects ADD/SUB, mode 10 selects AND/OR,
    // KEY0 picks the first of the pair.
    function automatic logic [1:0] bin_op(input logic [1:0] mode, input logic [1:0] press);
        logic [1:0] op;
        if (mode == 2'b01) op = press[0] ? ALU_ADD : ALU_SUB;
        else               op = press[0] ? ALU_AND : ALU_OR;
        return op;
    endfunction

endpackage

// File: rtl/key_edge.sv
// key_edge: falling-edge press detector for the active-low front-panel keys.
// Macro RPN_CTRL_SYNC_EN inserts a two-flop synchronizer ahead of the detector.
// Detection stays disarmed for the first edges after reset so that a key held
// down through reset release never produces a press.
module key_edge
    import rpn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] press
);

    logic [KEY_W-1:0] key_s;
    logic [KEY_W-1:0] hist;
    logic [1:0]       arm_cnt;
    logic             armed;

`ifdef RPN_CTRL_SYNC_EN
    localparam logic [1:0] ARM_CYC = 2'd3;

    logic [KEY_W-1:0] sync1;
    logic [KEY_W-1:0] sync2;

    // Two-flop synchronizer; idles at "released" out of reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    assign key_s = sync2;
`else
    localparam logic [1:0] ARM_CYC = 2'd1;

    assign key_s = key;
`endif

    // Key history and arming counter; armed once the pipeline holds post-reset samples.
    // NOTE: reset is synchronous (sampled inside the clocked block), so rst is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist    <= '1;
            arm_cnt <= '0;
        end else begin
            hist <= key_s;
            if (!armed) arm_cnt <= arm_cnt + 2'd1;
        end
    end

    assign armed = (arm_cnt == ARM_CYC);
    assign press = armed ? (hist & ~key_s) : '0;

endmodule

// File: rtl/rpn_ctrl.sv
// rpn_ctrl: command sequencer for the RPN calculator stack register file and ALU.
// Decodes key presses into push/pop/clear/binary-op sequences, owns the stack
// pointer and flags rejected commands. Macro RPN_CTRL_SYNC_EN (see key_edge)
// adds a key synchronizer and two cycles of latency to every command.
module rpn_ctrl
    import rpn_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DEPTH_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [KEY_W-1:0]   key,
    input  logic [DATA_W-1:0]  val,
    input  logic [DATA_W-1:0]  alu_y,
    output logic [1:0]         alu_op,
    output logic [DEPTH_W-1:0] rf_raddr1,
    output logic [DEPTH_W-1:0] rf_raddr2,
    output logic               rf_we,
    output logic [DEPTH_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic [7:0]         counter,
    output logic               top_vld,
    output logic               next_vld,
    output logic               busy,
    output logic               err
);

    localparam logic [DEPTH_W:0]   CAP   = {1'b1, {DEPTH_W{1'b0}}};
    localparam logic [DEPTH_W:0]   ONE   = {{DEPTH_W{1'b0}}, 1'b1};
    localparam logic [DEPTH_W-1:0] TWO_A = {{(DEPTH_W-2){1'b0}}, 2'b10};

    state_e              state, state_nxt;
    cmd_e                cmd;
    logic [KEY_W-1:0]    press;
    logic [DEPTH_W:0]    cnt, cnt_nxt;
    logic [DEPTH_W:0]    cnt_m1, cnt_p1;
    logic                cnt_lt2;
    logic                err_q, err_nxt;
    logic [DATA_W-1:0]   val_q, val_nxt;
    logic [1:0]          op_q, op_nxt;

    key_edge u_key_edge (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .press (press)
    );

    assign cnt_m1  = cnt - ONE;
    assign cnt_p1  = cnt + ONE;
    assign cnt_lt2 = (cnt[DEPTH_W:1] == '0);

    assign rf_raddr1 = (cnt == '0) ? '0 : cnt_m1[DEPTH_W-1:0];
    assign rf_raddr2 = cnt_lt2     ? '0 : (cnt[DEPTH_W-1:0] - TWO_A);

    assign counter  = 8'(cnt);
    assign top_vld  = (cnt != '0);
    assign next_vld = !cnt_lt2;
    assign err      = err_q;
    assign alu_op   = op_q;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Stack pointer, error flag and latched command operands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= '0;
            err_q <= 1'b0;
            val_q <= '0;
            op_q  <= ALU_ADD;
        end else begin
            cnt   <= cnt_nxt;
            err_q <= err_nxt;
            val_q <= val_nxt;
            op_q  <= op_nxt;
        end
    end

    // Next-state, register-file strobes and command acceptance.
    // NOTE: every output of this block is given a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err_q;
        val_nxt   = val_q;
        op_nxt    = op_q;
        busy      = 1'b1;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        cmd       = decode_cmd(mode, press[1:0]);

        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (|press) begin
                    unique case (cmd)
                        CMD_PUSH: begin
                            if (cnt == CAP) begin
                                err_nxt = 1'b1;
                            end else begin
                                err_nxt   = 1'b0;
                                val_nxt   = val;
                                state_nxt = PUSH;
                            end
                        end
                        CMD_POP: begin
                            if (cnt == '0) begin
                                err_nxt = 1'b1;
                            end else begin
                                err_nxt   = 1'b0;
                                state_nxt = POP;
                            end
                        end
                        CMD_CLR: begin
                            err_nxt   = 1'b0;
                            state_nxt = CLR;
                        end
                        CMD_BIN: begin
                            if (cnt_lt2) begin
                                err_nxt = 1'b1;
                            end else begin
                                err_nxt   = 1'b0;
                                op_nxt    = bin_op(mode, press[1:0]);
                                state_nxt = READ;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            PUSH: begin
                rf_we     = 1'b1;
                rf_waddr  = cnt[DEPTH_W-1:0];
                rf_wdata  = val_q;
                cnt_nxt   = cnt_p1;
                state_nxt = IDLE;
            end
            POP: begin
                cnt_nxt   = cnt_m1;
                state_nxt = IDLE;
            end
            CLR: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            // Operands are addressed now; the register file returns them next cycle.
            READ: begin
                state_nxt = WRITE;
            end
            // Result replaces the second entry, and the stack shrinks by one.
            WRITE: begin
                rf_we     = 1'b1;
                rf_waddr  = rf_raddr2;
                rf_wdata  = alu_y;
                cnt_nxt   = cnt_m1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
